rgb_pwm_driver: RTL and testbench
=================================

Name: rgb_pwm_driver

Overview:
- Downstream stage of the color decoder.
- Consumes the 48-bit packed colour word: four LEDs × 12-bit RGB, 4 bits per channel.
- Drives 4 discrete RGB LEDs (12 pins) with 4-bit PWM, 15-step period.
- The colour word is captured into a shadow register only at PWM period boundaries, so LEDs never glitch mid-period.

Parameters:
- CLK_DIV, 390, system clocks per PWM step (>=1). PWM period = 15*CLK_DIV clocks.
- INVERT, 0, 1 = active-low LED pins; every LED output is XORed with INVERT.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- fullColor  input  48  packed colours from the decoder. LED k uses [12k+11:12k].
  - R = [12k+11:12k+8], G = [12k+7:12k+4], B = [12k+3:12k].
- enable  input  1  0 forces all LEDs off; counters keep running.
- led_r  output  4  red pin per LED, bit k = LED k, registered.
- led_g  output  4  green pin per LED, registered.
- led_b  output  4  blue pin per LED, registered.
- frame_start  output  1  one-cycle pulse on the cycle the shadow register loads.

Behaviour:
- One clock, one always-block domain. Reset is synchronous, active-high, and dominates everything.
- Reset values:
  - pre_cnt = 0, pwm_cnt = 0, shadow = 48'h0, frame_start = 0.
  - led_r/g/b = {4{INVERT}}.
- Prescaler:
  - pre_cnt counts 0..CLK_DIV-1.
  - tick is asserted combinationally when pre_cnt == CLK_DIV-1; pre_cnt then wraps to 0.
  - With CLK_DIV = 1, tick is asserted every cycle.
- PWM counter (4 bits, range 0..14), updated on tick:
  - pwm_cnt == 14: pwm_cnt <= 0, shadow <= fullColor, frame_start <= 1.
  - Otherwise: pwm_cnt <= pwm_cnt + 1.
  - frame_start <= 0 on every other cycle.
  - pwm_cnt never takes the value 15.
- Output compare, every cycle, using pre-edge values of shadow, pwm_cnt and enable:
  - led_c[k] <= INVERT ^ (enable & (shadow_c[k] > pwm_cnt)).
  - Latency: one clock from counter/enable to pin.
- Duty:
  - Nibble d gives d high steps out of 15. d = 0 is always off; d = F is always on.
  - Pin-high time per period = d*CLK_DIV clocks.
- Shadow timing:
  - Changes on fullColor between boundaries are ignored.
  - A value present on the boundary-tick cycle is captured.
  - The new duty appears on the pins one clock after frame_start.
- First load:
  - After reset release, shadow stays 0 (LEDs off) until the first boundary.
  - The first frame_start occurs exactly 15*CLK_DIV clocks after the first non-reset cycle.
- enable:
  - Takes effect on pins one clock after it changes.
  - Does not stop pre_cnt, pwm_cnt, shadow loads or frame_start.
- Reset mid-period: all counters and the shadow clear on the next edge. Pins return to {4{INVERT}} on that same edge.
- Simultaneous fullColor change and boundary tick: the new value is captured (sampled at that edge).

Test Plan:
- Reset check (CLK_DIV=2, INVERT=0): assert rst 3 cycles.
  - Required: led_* = 0, frame_start = 0.
  - Required: first frame_start 30 clocks after release.
  - Reassert rst at clock 12 → counters restart, next frame_start 30 clocks after the second release.
- Static colours: fullColor = 48'hF00_0F0_00F_FF0, enable = 1.
  - Required after frame_start+1: led_r = 4'b1001, led_g = 4'b0101, led_b = 4'b0010, constant over 3 full periods.
- Duty measurement: all nibbles = 4'h5.
  - Required: each pin high exactly 10 of every 30 clocks, rising one clock after frame_start.
  - Nibble 4'hE: high 28 of 30.
- Mid-period update: load 48'h0 at a boundary, change to 48'hFFF_FFF_FFF_FFF at step 7.
  - Required: pins stay 0 until the next frame_start.
  - Required: pins all 1 from frame_start+1.
- Enable gating: full-white colour, drop enable for 40 clocks.
  - Required: all pins 0 from the next clock.
  - Required: frame_start still pulses every 30 clocks.
  - Required: pins return to 1 one clock after enable rises.
- Inverted pins (INVERT=1): during reset, pins = 4'hF.
  - Colour 48'h000_000_000_000 → pins constantly 1.
  - Colour all 4'hF → pins constantly 0 after first frame_start+1.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// Four-LED RGB PWM driver: 4-bit duty per channel over a 15-step period.
// The colour word is shadowed at period boundaries so pins never glitch mid-period.
module rgb_pwm_driver #(
    parameter int unsigned CLK_DIV = 390,
    parameter bit          INVERT  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] fullColor,
    input  logic        enable,
    output logic [3:0]  led_r,
    output logic [3:0]  led_g,
    output logic [3:0]  led_b,
    output logic        frame_start
);

    localparam int unsigned PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [3:0]  PWM_LAST = 4'd14;

    logic [PRE_W-1:0] r_pre_cnt;
    logic [3:0]       r_pwm_cnt;
    logic [47:0]      r_shadow;
    logic             r_frame_start;
    logic [3:0]       r_led_r;
    logic [3:0]       r_led_g;
    logic [3:0]       r_led_b;

    logic             w_tick;
    logic [3:0]       w_on_r;
    logic [3:0]       w_on_g;
    logic [3:0]       w_on_b;

    assign w_tick = (r_pre_cnt == PRE_W'(CLK_DIV - 1));

    // Per-LED compare of the shadowed nibble against the current PWM step.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_on_r = '0;
        w_on_g = '0;
        w_on_b = '0;
        for (int k = 0; k < 4; k++) begin
            w_on_r[k] = enable & (r_shadow[12*k+8 +: 4] > r_pwm_cnt);
            w_on_g[k] = enable & (r_shadow[12*k+4 +: 4] > r_pwm_cnt);
            w_on_b[k] = enable & (r_shadow[12*k   +: 4] > r_pwm_cnt);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, which the one-clock pin latency relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow is reset (unlike a RAM) because LEDs must stay dark until the first load.
            r_pre_cnt     <= '0;
            r_pwm_cnt     <= '0;
            r_shadow      <= '0;
            r_frame_start <= 1'b0;
            r_led_r       <= {4{INVERT}};
            r_led_g       <= {4{INVERT}};
            r_led_b       <= {4{INVERT}};
        end else begin
            r_frame_start <= 1'b0;
            r_pre_cnt     <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);

            if (w_tick) begin
                if (r_pwm_cnt == PWM_LAST) begin
                    r_pwm_cnt     <= '0;
                    r_shadow      <= fullColor;
                    r_frame_start <= 1'b1;
                end else begin
                    r_pwm_cnt <= r_pwm_cnt + 4'd1;
                end
            end

            r_led_r <= {4{INVERT}} ^ w_on_r;
            r_led_g <= {4{INVERT}} ^ w_on_g;
            r_led_b <= {4{INVERT}} ^ w_on_b;
        end
    end

    assign led_r       = r_led_r;
    assign led_g       = r_led_g;
    assign led_b       = r_led_b;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: two instances (INVERT=0/1) at CLK_DIV=2, 30-clock period.
module tb_rgb_pwm_driver;

    localparam logic [47:0] WHITE  = 48'hFFF_FFF_FFF_FFF;
    localparam logic [47:0] STATIC = 48'hF00_0F0_00F_FF0;
    localparam logic [47:0] ALL5   = 48'h555_555_555_555;
    localparam logic [47:0] ALLE   = 48'hEEE_EEE_EEE_EEE;
    localparam logic [11:0] STATIC_PINS = {4'b1001, 4'b0101, 4'b0010};

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] fullColor;
    logic        enable;
    logic [3:0]  led_r0, led_g0, led_b0, led_r1, led_g1, led_b1;
    logic        fs0, fs1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.CLK_DIV(2), .INVERT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .fullColor(fullColor), .enable(enable),
        .led_r(led_r0), .led_g(led_g0), .led_b(led_b0), .frame_start(fs0)
    );

    rgb_pwm_driver #(.CLK_DIV(2), .INVERT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .fullColor(fullColor), .enable(enable),
        .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .frame_start(fs1)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp is the non-inverted pin pattern {r,g,b}; the inverted instance must show its complement.
    task automatic check_pins(input string tag, input logic [11:0] exp);
        check({tag, "_inv0"}, {36'h0, led_r0, led_g0, led_b0}, {36'h0, exp});
        check({tag, "_inv1"}, {36'h0, led_r1, led_g1, led_b1}, {36'h0, ~exp});
    endtask

    // Waits for the next frame_start and checks how many clocks it took.
    task automatic wait_fs(input string tag, input int exp);
        int  cnt   = 0;
        bit  found = 1'b0;
        while (!found && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (fs0) found = 1'b1;
        end
        check(tag, 48'(cnt), 48'(exp));
        check({tag, "_inv1"}, {47'h0, fs1}, 48'h1);
    endtask

    // Starting at a frame_start, checks a full period for nibble d on every pin.
    task automatic measure(input string tag, input int d);
        int highs = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check_pins(tag, (i <= 2 * d) ? 12'hFFF : 12'h000);
            if (led_r0[0]) highs++;
        end
        check({tag, "_highs"}, 48'(highs), 48'(2 * d));
        check({tag, "_fs"}, {47'h0, fs0}, 48'h1);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        fullColor = WHITE;
        repeat (3) @(negedge clk);
        check_pins("reset", 12'h000);
        check("reset_fs", {47'h0, fs0}, 48'h0);

        rst = 1'b0;
        wait_fs("first_fs", 30);

        repeat (12) @(negedge clk);
        check_pins("white_before_rerst", 12'hFFF);
        rst = 1'b1;
        @(negedge clk);
        check_pins("rerst", 12'h000);
        check("rerst_fs", {47'h0, fs0}, 48'h0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_pins("shadow_cleared", 12'h000);
        wait_fs("fs_after_rerst", 18);

        fullColor = STATIC;
        wait_fs("fs_period", 30);
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            check_pins("static", STATIC_PINS);
        end

        fullColor = ALL5;
        wait_fs("fs_load5", 30);
        fullColor = ALLE;
        measure("duty5", 5);
        fullColor = 48'h0;
        measure("dutyE", 14);

        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check_pins("mid_update_hold", 12'h000);
            if (i == 14) fullColor = WHITE;
        end
        check("mid_update_fs", {47'h0, fs0}, 48'h1);
        @(negedge clk);
        check_pins("mid_update_new", 12'hFFF);

        enable = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            check_pins("enable_off", 12'h000);
            check("enable_off_fs", {47'h0, fs0}, {47'h0, (j == 29)});
        end
        enable = 1'b1;
        @(negedge clk);
        check_pins("enable_on", 12'hFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
